hangman_game_ctrl: RTL and testbench
====================================

Name: hangman_game_ctrl

Overview:
- Top-level game sequencer for the two-player hangman datapath.
- Drives the datapath's control strobes: ld, ld_g, writeorread, wren, rden, compare, fill, draw, over, timecount.
- Reacts to the datapath status lines (match, finish, graph_loaded, timeout) and to keyboard events.
- Owns word-length and miss bookkeeping and decides win/lose for each round.

Parameters:
MAX_LEN, 16, maximum characters per secret word
LEN_W, 5, width of word_len (must hold MAX_LEN)
MAX_MISSES, 6, wrong guesses that end the round (head, body, 2 arms, 2 legs)

Ports:
clk  in  1  system clock
resetn  in  1  asynchronous active-low reset
start  in  1  1-cycle pulse, begin new round
char_valid  in  1  1-cycle pulse, setter typed a character
word_done  in  1  1-cycle pulse, setter finished the word
guess_valid  in  1  1-cycle pulse, guesser typed a character
match  in  1  compare result, valid only while cmp_done=1
cmp_done  in  1  compare scan over all addresses finished
fill_done  in  1  letter fill drawing finished
finish  in  1  dash/part drawing finished
graph_loaded  in  1  gallows drawing finished
remain_zero  in  1  no unrevealed letters remain
timeout  in  1  guess timer expired (level or pulse)
clear_done  in  1  screen wipe finished
ld, wren  out  1  load/write one setter character
ld_g  out  1  draw gallows
writeorread  out  1  draw dashes
rden, compare  out  1  run compare scan
fill  out  1  fill matched letters
draw  out  1  draw next body part
over  out  1  wipe screen
timecount  out  1  guess timer enable
word_len  out  LEN_W  characters loaded
miss_count  out  3  wrong guesses this round
win, lose  out  1  round result flags
state  out  4  current state, for debug/HEX

Behaviour:
- Reset: asynchronous. All outputs are 0, state is IDLE, and word_len, miss_count and timeout_pend are 0. Reset mid-operation aborts immediately; no strobe survives.
- Moore machine: every strobe is a function of the registered state only. A strobe rises in the first cycle after the triggering input is sampled.
- Done handshake: on the edge where the done input is 1, the state advances, so the strobe is low in the following cycle. A done input seen outside its matching state is ignored.
- States and transitions:
  - IDLE: outputs 0, win/lose held. On start: clear word_len, miss_count, win, lose, timeout_pend, then go to LOAD.
  - LOAD:
    - char_valid with word_len<MAX_LEN: ld=wren=1 for exactly 1 cycle, word_len+1. Back-to-back char_valid gives back-to-back pulses.
    - char_valid at word_len==MAX_LEN: ignored, no pulse.
    - word_done with word_len>0: go to GRAPH. word_done with word_len==0 is ignored.
    - char_valid and word_done in the same cycle: the char is loaded first (if not full), then GRAPH.
  - GRAPH: ld_g=1 until graph_loaded, then DASH.
  - DASH: writeorread=1 until finish, then WAIT.
  - WAIT: timecount=1. guess_valid goes to CMP. timeout goes to LOSE; if both in the same cycle, timeout wins.
  - CMP: rden=compare=timecount=1. On cmp_done: match=1 goes to FILL; match=0 increments miss_count (saturating at MAX_MISSES) and goes to DRAW.
  - FILL: fill=timecount=1 until fill_done, then CHECK.
  - DRAW: draw=timecount=1 until finish, then CHECK.
  - CHECK (1 cycle, timecount=1), priority in this order:
    1. remain_zero goes to WIN.
    2. timeout_pend or timeout goes to LOSE.
    3. miss_count==MAX_MISSES goes to LOSE.
    4. Otherwise WAIT.
  - WIN / LOSE: 1 cycle; set win or lose (held until next start), then OVER.
  - OVER: over=1 until clear_done, then IDLE.
- timeout seen in CMP/FILL/DRAW sets timeout_pend; the current sub-operation completes first.
- guess_valid outside WAIT is dropped (no queue).
- start outside IDLE is ignored.
- Strobe exclusivity: at most one of ld, ld_g, writeorread, compare, fill, draw, over is high in any cycle.
- win and lose are never both 1.
- Unused state encodings recover to IDLE on the next edge.

Test Plan:
- start; 3 char_valid; word_done → ld/wren pulse 3 times, word_len=3; ld_g high until graph_loaded; writeorread high until finish; state=WAIT with timecount=1.
- In WAIT, guess_valid; cmp_done with match=1; fill_done; remain_zero=1 → fill high 1+ cycles, then win=1, lose=0; over high until clear_done; state returns to IDLE.
- 6 guesses each answered cmp_done with match=0, finish after each → draw high 6 times, miss_count goes 1..6, lose=1 after the 6th CHECK.
- 17 char_valid with MAX_LEN=16 → exactly 16 ld pulses, word_len=16. word_done at word_len=0 (fresh round) → stays in LOAD.
- timeout pulsed during DRAW → draw stays high until finish, then CHECK, then LOSE (lose=1) even with miss_count=1.
- resetn low in the middle of FILL → all strobes 0 asynchronously, state=IDLE, word_len=0; after resetn high, fill_done is ignored.

Source files
------------

// File: rtl/hangman_game_ctrl.sv
// hangman_game_ctrl: round sequencer for the two-player hangman datapath.
//   in : clk, resetn (async, active low), start, char_valid, word_done, guess_valid,
//        match, cmp_done, fill_done, finish, graph_loaded, remain_zero, timeout, clear_done
//   out: ld/wren, ld_g, writeorread, rden/compare, fill, draw, over, timecount strobes,
//        word_len, miss_count, win/lose round result, state (debug)
module hangman_game_ctrl #(
  parameter int MAX_LEN    = 16,
  parameter int LEN_W      = 5,
  parameter int MAX_MISSES = 6
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic             char_valid,
  input  logic             word_done,
  input  logic             guess_valid,
  input  logic             match,
  input  logic             cmp_done,
  input  logic             fill_done,
  input  logic             finish,
  input  logic             graph_loaded,
  input  logic             remain_zero,
  input  logic             timeout,
  input  logic             clear_done,
  output logic             ld,
  output logic             wren,
  output logic             ld_g,
  output logic             writeorread,
  output logic             rden,
  output logic             compare,
  output logic             fill,
  output logic             draw,
  output logic             over,
  output logic             timecount,
  output logic [LEN_W-1:0] word_len,
  output logic [2:0]       miss_count,
  output logic             win,
  output logic             lose,
  output logic [3:0]       state
);
  typedef enum logic [3:0] {
    IDLE, LOAD, GRAPH, DASH, WAIT, CMP, FILL, DRAW, CHECK, WIN, LOSE, OVER
  } state_t;
  state_t           state_q, state_d;
  logic [LEN_W-1:0] word_len_q, word_len_d;
  logic [2:0]       miss_q, miss_d;
  logic             win_q, win_d, lose_q, lose_d;
  logic             tpend_q, tpend_d;
  logic             ld_q, ld_d;
  logic             dpend_q, dpend_d;
  logic             char_ok;
  always_comb begin
    state_d    = state_q;
    word_len_d = word_len_q;
    miss_d     = miss_q;
    win_d      = win_q;
    lose_d     = lose_q;
    tpend_d    = tpend_q;
    dpend_d    = dpend_q;
    ld_d       = 1'b0;
    char_ok    = char_valid && (word_len_q < LEN_W'(MAX_LEN));
    case (state_q)
      IDLE: if (start) begin
        word_len_d = '0;
        miss_d     = '0;
        win_d      = 1'b0;
        lose_d     = 1'b0;
        tpend_d    = 1'b0;
        dpend_d    = 1'b0;
        state_d    = LOAD;
      end
      LOAD: begin
        // A char arriving with word_done is pulsed first; GRAPH follows one cycle later
        // so ld never overlaps ld_g.
        if (dpend_q) begin
          dpend_d = 1'b0;
          state_d = GRAPH;
        end else begin
          if (char_ok) begin
            ld_d       = 1'b1;
            word_len_d = word_len_q + LEN_W'(1);
          end
          if (word_done && char_ok) dpend_d = 1'b1;
          else if (word_done && word_len_q != '0) state_d = GRAPH;
        end
      end
      GRAPH: state_d = graph_loaded ? DASH : GRAPH;
      DASH:  state_d = finish ? WAIT : DASH;
      WAIT:  state_d = timeout ? LOSE : guess_valid ? CMP : WAIT;
      CMP: begin
        tpend_d = tpend_q | timeout;
        if (cmp_done) begin
          state_d = match ? FILL : DRAW;
          if (!match && miss_q != 3'(MAX_MISSES)) miss_d = miss_q + 3'd1;
        end
      end
      FILL: begin
        tpend_d = tpend_q | timeout;
        state_d = fill_done ? CHECK : FILL;
      end
      DRAW: begin
        tpend_d = tpend_q | timeout;
        state_d = finish ? CHECK : DRAW;
      end
      CHECK: state_d = remain_zero ? WIN
                     : (tpend_q || timeout || miss_q == 3'(MAX_MISSES)) ? LOSE : WAIT;
      WIN: begin
        win_d   = 1'b1;
        state_d = OVER;
      end
      LOSE: begin
        lose_d  = 1'b1;
        state_d = OVER;
      end
      OVER:    state_d = clear_done ? IDLE : OVER;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      word_len_q <= '0;
      miss_q     <= '0;
      win_q      <= 1'b0;
      lose_q     <= 1'b0;
      tpend_q    <= 1'b0;
      ld_q       <= 1'b0;
      dpend_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      word_len_q <= word_len_d;
      miss_q     <= miss_d;
      win_q      <= win_d;
      lose_q     <= lose_d;
      tpend_q    <= tpend_d;
      ld_q       <= ld_d;
      dpend_q    <= dpend_d;
    end
  end
  assign ld          = ld_q;
  assign wren        = ld_q;
  assign ld_g        = state_q == GRAPH;
  assign writeorread = state_q == DASH;
  assign rden        = state_q == CMP;
  assign compare     = state_q == CMP;
  assign fill        = state_q == FILL;
  assign draw        = state_q == DRAW;
  assign over        = state_q == OVER;
  assign timecount   = state_q inside {WAIT, CMP, FILL, DRAW, CHECK};
  assign word_len    = word_len_q;
  assign miss_count  = miss_q;
  assign win         = win_q;
  assign lose        = lose_q;
  assign state       = state_q;
endmodule

// File: tb/tb_hangman_game_ctrl.sv
// tb_hangman_game_ctrl: randomized scenario bench for the hangman round sequencer.
module tb_hangman_game_ctrl;
  logic clk = 0, resetn = 0;
  logic start = 0, char_valid = 0, word_done = 0, guess_valid = 0, match = 0, cmp_done = 0;
  logic fill_done = 0, finish = 0, graph_loaded = 0, remain_zero = 0, timeout = 0, clear_done = 0;
  logic ld, wren, ld_g, writeorread, rden, compare, fill, draw, over, timecount, win, lose;
  logic [4:0] word_len;
  logic [2:0] miss_count;
  logic [3:0] state;
  int vectors = 0, errs = 0;
  localparam logic [9:0] Z = 10'b0000000000, LDW = 10'b1100000000, G = 10'b0010000000,
    D = 10'b0001000000, C = 10'b0000110001, F = 10'b0000001001, DR = 10'b0000000101,
    O = 10'b0000000010, T = 10'b0000000001;
  wire [9:0] strb = {ld, wren, ld_g, writeorread, rden, compare, fill, draw, over, timecount};
  hangman_game_ctrl dut (
    .clk(clk), .resetn(resetn), .start(start), .char_valid(char_valid), .word_done(word_done),
    .guess_valid(guess_valid), .match(match), .cmp_done(cmp_done), .fill_done(fill_done),
    .finish(finish), .graph_loaded(graph_loaded), .remain_zero(remain_zero), .timeout(timeout),
    .clear_done(clear_done), .ld(ld), .wren(wren), .ld_g(ld_g), .writeorread(writeorread),
    .rden(rden), .compare(compare), .fill(fill), .draw(draw), .over(over),
    .timecount(timecount), .word_len(word_len), .miss_count(miss_count), .win(win),
    .lose(lose), .state(state));
  always #5 clk = ~clk;
  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic do_reset();
    resetn = 0;
    cyc();
    resetn = 1;
    cyc();
  endtask
  task automatic reach_wait(input int n);
    start = 1; cyc(); start = 0;
    for (int i = 0; i < n; i++) begin
      char_valid = 1; cyc(); char_valid = 0;
    end
    word_done = 1; cyc(); word_done = 0;
    graph_loaded = 1; cyc(); graph_loaded = 0;
    finish = 1; cyc(); finish = 0;
  endtask
  task automatic test_reset();
    resetn = 0;
    cyc(2);
    vectors++; if (strb !== Z) begin errs++; $display("FAIL reset_strobes: got %b want %b", strb, Z); end
    vectors++; if (word_len !== 5'd0 || miss_count !== 3'd0) begin errs++; $display("FAIL reset_counts: got len=%0d miss=%0d want 0/0", word_len, miss_count); end
    vectors++; if (win !== 1'b0 || lose !== 1'b0) begin errs++; $display("FAIL reset_result: got win=%b lose=%b want 0/0", win, lose); end
    resetn = 1;
    cyc();
  endtask
  task automatic test_load_basic();
    start = 1; cyc(); start = 0;
    vectors++; if (strb !== Z) begin errs++; $display("FAIL load_enter: got %b want %b", strb, Z); end
    char_valid = 1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      vectors++; if (strb !== LDW) begin errs++; $display("FAIL load_pulse%0d: got %b want %b", i, strb, LDW); end
    end
    char_valid = 0;
    cyc();
    vectors++; if (strb !== Z || word_len !== 5'd3) begin errs++; $display("FAIL load_after: got %b len=%0d want %b len=3", strb, word_len, Z); end
    word_done = 1; cyc(); word_done = 0;
    cyc($urandom_range(0, 3));
    vectors++; if (strb !== G) begin errs++; $display("FAIL graph: got %b want %b", strb, G); end
    graph_loaded = 1; cyc(); graph_loaded = 0;
    cyc($urandom_range(0, 3));
    vectors++; if (strb !== D) begin errs++; $display("FAIL dash: got %b want %b", strb, D); end
    finish = 1; cyc(); finish = 0;
    vectors++; if (strb !== T) begin errs++; $display("FAIL wait: got %b want %b", strb, T); end
  endtask
  task automatic test_win();
    guess_valid = 1; cyc(); guess_valid = 0;
    vectors++; if (strb !== C) begin errs++; $display("FAIL win_cmp: got %b want %b", strb, C); end
    match = 1; cmp_done = 1; cyc(); match = 0; cmp_done = 0;
    cyc($urandom_range(0, 2));
    vectors++; if (strb !== F || miss_count !== 3'd0) begin errs++; $display("FAIL win_fill: got %b miss=%0d want %b miss=0", strb, miss_count, F); end
    fill_done = 1; cyc(); fill_done = 0;
    vectors++; if (strb !== T) begin errs++; $display("FAIL win_check: got %b want %b", strb, T); end
    remain_zero = 1; cyc(); remain_zero = 0;
    vectors++; if (strb !== Z) begin errs++; $display("FAIL win_state: got %b want %b", strb, Z); end
    cyc();
    vectors++; if (win !== 1'b1 || lose !== 1'b0) begin errs++; $display("FAIL win_flags: got win=%b lose=%b want 1/0", win, lose); end
    cyc(3);
    vectors++; if (strb !== O) begin errs++; $display("FAIL win_over: got %b want %b", strb, O); end
    clear_done = 1; cyc(); clear_done = 0;
    vectors++; if (strb !== Z || win !== 1'b1) begin errs++; $display("FAIL win_idle: got %b win=%b want %b win=1", strb, win, Z); end
    char_valid = 1; cyc(); char_valid = 0;
    vectors++; if (strb !== Z) begin errs++; $display("FAIL idle_char: got %b want %b", strb, Z); end
    start = 1; cyc(); start = 0;
    vectors++; if (win !== 1'b0 || word_len !== 5'd0) begin errs++; $display("FAIL start_clear: got win=%b len=%0d want 0/0", win, word_len); end
    do_reset();
  endtask
  task automatic test_lose_misses();
    reach_wait(5);
    for (int i = 1; i <= 6; i++) begin
      guess_valid = 1; cyc(); guess_valid = 0;
      cmp_done = 1; match = 0; cyc(); cmp_done = 0;
      vectors++; if (strb !== DR || miss_count !== 3'(i)) begin errs++; $display("FAIL miss%0d_draw: got %b miss=%0d want %b miss=%0d", i, strb, miss_count, DR, i); end
      finish = 1; cyc(); finish = 0;
      cyc();
      vectors++; if (strb !== (i < 6 ? T : Z)) begin errs++; $display("FAIL miss%0d_after: got %b want %b", i, strb, (i < 6 ? T : Z)); end
    end
    cyc();
    vectors++; if (strb !== O || lose !== 1'b1 || win !== 1'b0) begin errs++; $display("FAIL miss_lose: got %b lose=%b win=%b want %b 1/0", strb, lose, win, O); end
    clear_done = 1; cyc(); clear_done = 0;
  endtask
  task automatic test_back_to_back();
    int pulses = 0;
    start = 1; cyc(); start = 0;
    char_valid = 1;
    for (int i = 0; i < 17; i++) begin
      cyc();
      if (strb === LDW) pulses++;
    end
    char_valid = 0;
    vectors++; if (pulses != 16 || word_len !== 5'd16) begin errs++; $display("FAIL overflow: got pulses=%0d len=%0d want 16/16", pulses, word_len); end
    do_reset();
    start = 1; cyc(); start = 0;
    word_done = 1; cyc(); word_done = 0;
    vectors++; if (strb !== Z) begin errs++; $display("FAIL empty_done: got %b want %b", strb, Z); end
    char_valid = 1; cyc(); char_valid = 0;
    vectors++; if (strb !== LDW || word_len !== 5'd1) begin errs++; $display("FAIL still_load: got %b len=%0d want %b len=1", strb, word_len, LDW); end
    char_valid = 1; word_done = 1; cyc(); char_valid = 0; word_done = 0;
    vectors++; if (strb !== LDW || word_len !== 5'd2) begin errs++; $display("FAIL same_cycle_ld: got %b len=%0d want %b len=2", strb, word_len, LDW); end
    cyc();
    vectors++; if (strb !== G) begin errs++; $display("FAIL same_cycle_graph: got %b want %b", strb, G); end
    start = 1; guess_valid = 1; cyc(); start = 0; guess_valid = 0;
    vectors++; if (strb !== G || word_len !== 5'd2) begin errs++; $display("FAIL ignore_in_graph: got %b len=%0d want %b len=2", strb, word_len, G); end
    do_reset();
  endtask
  task automatic test_timeout_draw();
    reach_wait(4);
    guess_valid = 1; cyc(); guess_valid = 0;
    cmp_done = 1; cyc(); cmp_done = 0;
    timeout = 1; cyc(); timeout = 0;
    cyc(2);
    vectors++; if (strb !== DR) begin errs++; $display("FAIL tmo_draw: got %b want %b", strb, DR); end
    finish = 1; cyc(); finish = 0;
    vectors++; if (strb !== T) begin errs++; $display("FAIL tmo_check: got %b want %b", strb, T); end
    cyc(2);
    vectors++; if (strb !== O || lose !== 1'b1 || miss_count !== 3'd1) begin errs++; $display("FAIL tmo_lose: got %b lose=%b miss=%0d want %b 1 1", strb, lose, miss_count, O); end
    clear_done = 1; cyc(); clear_done = 0;
  endtask
  task automatic test_reset_mid_fill();
    reach_wait(2);
    guess_valid = 1; cyc(); guess_valid = 0;
    match = 1; cmp_done = 1; cyc(); match = 0; cmp_done = 0;
    vectors++; if (strb !== F) begin errs++; $display("FAIL rst_fill: got %b want %b", strb, F); end
    #2 resetn = 0;
    #1;
    vectors++; if (strb !== Z || word_len !== 5'd0) begin errs++; $display("FAIL rst_async: got %b len=%0d want %b len=0", strb, word_len, Z); end
    cyc(); resetn = 1; cyc();
    fill_done = 1; cyc(); fill_done = 0;
    vectors++; if (strb !== Z) begin errs++; $display("FAIL rst_filldone: got %b want %b", strb, Z); end
  endtask
  task automatic test_random_round();
    int len, misses, res, r;
    bit m, rz, tm, done;
    len = $urandom_range(1, 16);
    misses = 0; res = 0; done = 0;
    reach_wait(len);
    vectors++; if (word_len !== 5'(len) || strb !== T) begin errs++; $display("FAIL rnd_load: got len=%0d %b want len=%0d %b", word_len, strb, len, T); end
    while (!done) begin
      r = $urandom_range(0, 9);
      if (r == 0) begin
        timeout = 1; guess_valid = $urandom_range(0, 1) == 1; cyc(); timeout = 0; guess_valid = 0;
        res = 2; done = 1;
      end else begin
        m = r >= 5;
        rz = m && $urandom_range(0, 2) == 0;
        tm = $urandom_range(0, 7) == 0;
        guess_valid = 1; cyc(); guess_valid = 0;
        cyc($urandom_range(0, 2));
        vectors++; if (strb !== C) begin errs++; $display("FAIL rnd_cmp: got %b want %b", strb, C); end
        match = m; cmp_done = 1; cyc(); match = 0; cmp_done = 0;
        if (!m && misses < 6) misses++;
        vectors++; if (strb !== (m ? F : DR) || miss_count !== 3'(misses)) begin errs++; $display("FAIL rnd_op: got %b miss=%0d want %b miss=%0d", strb, miss_count, (m ? F : DR), misses); end
        if (tm) begin
          timeout = 1; cyc(); timeout = 0;
        end
        if (m) fill_done = 1; else finish = 1;
        cyc(); fill_done = 0; finish = 0;
        remain_zero = rz; cyc(); remain_zero = 0;
        res = rz ? 1 : (tm || misses == 6) ? 2 : 0;
        if (res == 0) begin
          vectors++; if (strb !== T) begin errs++; $display("FAIL rnd_continue: got %b want %b", strb, T); end
        end else done = 1;
      end
    end
    vectors++; if (strb !== Z) begin errs++; $display("FAIL rnd_end: got %b want %b", strb, Z); end
    cyc();
    vectors++; if (strb !== O || win !== (res == 1) || lose !== (res == 2)) begin errs++; $display("FAIL rnd_result: got %b win=%b lose=%b want %b res=%0d", strb, win, lose, O, res); end
    clear_done = 1; cyc(); clear_done = 0;
  endtask
  initial begin
    test_reset();
    test_load_basic();
    test_win();
    test_lose_misses();
    test_back_to_back();
    test_timeout_draw();
    test_reset_mid_fill();
    for (int k = 0; k < 20; k++) test_random_round();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
